// File: rtl/demux12nr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux12nr_pkg
// Brief    : Shared pairing-FSM state encoding for the 1-to-2 demultiplexer.
// Revision : 1.0
// ============================================================================
package demux12nr_pkg;

    typedef logic [0:0] state_t;

    localparam logic [0:0] ST_LO = 1'b0;  // waiting for lane-0 sample
    localparam logic [0:0] ST_HI = 1'b1;  // lane-0 held, waiting for lane 1

endpackage : demux12nr_pkg
`default_nettype wire

// File: rtl/demux12nr_if.sv
`default_nettype none
// ============================================================================
// Module   : demux12nr_if
// Brief    : Sample-in / pair-out bundle; ovf/ovf_clr exist with DEMUX12NR_OVF_EN.
// Revision : 1.0
// ============================================================================
interface demux12nr_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             sync;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout0;
    logic [WIDTH-1:0] dout1;
    logic             dvalid;
    logic             dready;
`ifdef DEMUX12NR_OVF_EN
    logic             ovf;
    logic             ovf_clr;

    modport master (output en, sync, din, dready, ovf_clr,
                    input  dout0, dout1, dvalid, ovf);
    modport slave  (input  en, sync, din, dready, ovf_clr,
                    output dout0, dout1, dvalid, ovf);
`else
    modport master (output en, sync, din, dready,
                    input  dout0, dout1, dvalid);
    modport slave  (input  en, sync, din, dready,
                    output dout0, dout1, dvalid);
`endif
endinterface : demux12nr_if
`default_nettype wire

// File: rtl/demux12nr_slot.sv
`default_nettype none
// ============================================================================
// Module   : demux12nr_slot
// Brief    : Output pair register with valid/ready handshake; DEMUX12NR_OVF_EN
//            selects drop-and-flag instead of overwrite on a blocked slot.
// Revision : 1.0
// ============================================================================
module demux12nr_slot #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             complete,
    input  wire logic [WIDTH-1:0] new0,
    input  wire logic [WIDTH-1:0] new1,
    input  wire logic             dready,
`ifdef DEMUX12NR_OVF_EN
    input  wire logic             ovf_clr,
    output logic                  ovf,
`endif
    output logic [WIDTH-1:0]      dout0,
    output logic [WIDTH-1:0]      dout1,
    output logic                  dvalid
);

    logic [WIDTH-1:0] dout0_q, dout0_d;
    logic [WIDTH-1:0] dout1_q, dout1_d;
    logic             dvalid_q, dvalid_d;
    logic             slot_free;

    // The slot frees up on the same edge it is consumed, so a pair can chain in.
    assign slot_free = !dvalid_q || dready;

`ifdef DEMUX12NR_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr)
            ovf_d = 1'b0;
        if (complete && !slot_free)
            ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

    always_comb begin
        dout0_d  = dout0_q;
        dout1_d  = dout1_q;
        dvalid_d = dvalid_q;
        if (complete) begin
`ifdef DEMUX12NR_OVF_EN
            if (slot_free) begin
                dout0_d  = new0;
                dout1_d  = new1;
                dvalid_d = 1'b1;
            end
`else
            dout0_d  = new0;
            dout1_d  = new1;
            dvalid_d = 1'b1;
`endif
        end else if (dvalid_q && dready) begin
            dvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout0_q  <= '0;
            dout1_q  <= '0;
            dvalid_q <= 1'b0;
        end else begin
            dout0_q  <= dout0_d;
            dout1_q  <= dout1_d;
            dvalid_q <= dvalid_d;
        end
    end

    assign dout0  = dout0_q;
    assign dout1  = dout1_q;
    assign dvalid = dvalid_q;

endmodule : demux12nr_slot
`default_nettype wire

// File: rtl/demux12nr.sv
`default_nettype none
// ============================================================================
// Module   : demux12nr
// Brief    : Registered 1-to-2 sample demultiplexer; optional sticky overflow
//            flag enabled by DEMUX12NR_OVF_EN.
// Revision : 1.0
// ============================================================================
module demux12nr
    import demux12nr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic  clk,
    input  wire logic  rst,
    demux12nr_if.slave bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold0_q, hold0_d;
    logic             complete;

    // sync restarts pairing, so it also re-captures lane 0 while in ST_HI.
    always_comb begin
        state_d  = state_q;
        hold0_d  = hold0_q;
        complete = 1'b0;
        if (bus.en) begin
            if (state_q == ST_LO || bus.sync) begin
                hold0_d = bus.din;
                state_d = ST_HI;
            end else begin
                complete = 1'b1;
                state_d  = ST_LO;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LO;
            hold0_q <= '0;
        end else begin
            state_q <= state_d;
            hold0_q <= hold0_d;
        end
    end

    demux12nr_slot #(
        .WIDTH    (WIDTH)
    ) u_slot (
        .clk      (clk),
        .rst      (rst),
        .complete (complete),
        .new0     (hold0_q),
        .new1     (bus.din),
        .dready   (bus.dready),
`ifdef DEMUX12NR_OVF_EN
        .ovf_clr  (bus.ovf_clr),
        .ovf      (bus.ovf),
`endif
        .dout0    (bus.dout0),
        .dout1    (bus.dout1),
        .dvalid   (bus.dvalid)
    );

endmodule : demux12nr
`default_nettype wire

// File: doc/demux12nr.md
# demux12nr

Registered 1-to-2 sample demultiplexer for the logic-analyzer capture path: it takes a single strobed stream of `width`-bit samples and de-interleaves consecutive samples into two parallel lanes. Each completed pair is presented as one word with a valid/ready handshake toward the buffer writer. It sits between the sample front end and the capture memory interface, doubling the word width so the memory side runs at half the sample rate.

## Interface
- `width`, default 8: bits per sample; each lane is `width` bits wide.
- `clk` input 1: sole clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `en` input 1: sample strobe; `din` is accepted on every rising edge where `en`=1.
- `sync` input 1: qualified by `en`; forces the accepted sample into lane 0 and restarts pairing.
- `din` input `width`: sample data.
- `dout0` output `width`: earlier sample of the current pair.
- `dout1` output `width`: later sample of the current pair.
- `dvalid` output 1: the pair on `dout0`/`dout1` is valid.
- `dready` input 1: consumer accepts the pair on any edge where `dvalid`=1 and `dready`=1.
- `ovf` output 1, present only with `DEMUX12NR_OVF_EN`: sticky overflow flag.
- `ovf_clr` input 1, present only with `DEMUX12NR_OVF_EN`: synchronous clear for `ovf`.

## Operation
- Two-state FSM, `ST_LO` (waiting for the lane-0 sample) and `ST_HI` (lane-0 sample held, waiting for lane 1). Reset state is `ST_LO`.
- Internal hold register `hold0[width]`.
- In `ST_LO` with `en`=1: `hold0` <= `din`, go to `ST_HI`.
- In `ST_HI` with `en`=1 and `sync`=0: the pair completes. Go to `ST_LO` and run the pair-completion logic below.
- In `ST_HI` with `en`=1 and `sync`=1: `hold0` <= `din` and stay in `ST_HI`. The half-pair already held is discarded silently, with no `ovf`.
- With `en`=0, nothing changes except handshake consumption.
- Pair completion when the output slot is free (`dvalid`=0, or `dvalid`=1 and `dready`=1 in the same cycle):
  - `dout0` <= `hold0`, `dout1` <= `din`, `dvalid` <= 1.
- Pair completion when the output slot is blocked (`dvalid`=1 and `dready`=0): see Configuration.
- Consumption: `dvalid`=1 and `dready`=1 with no completing pair gives `dvalid` <= 0. `dout0` and `dout1` hold their last values.
- `dout0` and `dout1` never change while `dvalid`=1 and `dready`=0, except in the no-macro overwrite case.

## Timing
- Reset values: `dout0`=0, `dout1`=0, `dvalid`=0, `ovf`=0, `hold0`=0, FSM state `ST_LO`.
- Latency: a pair is visible on outputs one cycle after the edge that accepts its second sample.
- Throughput: one pair per two `en` strobes. Back-to-back `en` with `dready` held at 1 is sustained with no loss.
- Simultaneous consume and complete in the same cycle: the new pair is loaded and `dvalid` stays 1.
- Reset asserted mid-pair: the held sample is lost and pairing restarts at lane 0 after `rst` deasserts.

## Configuration
- `DEMUX12NR_OVF_EN` defined:
  - A blocked completion drops the new pair; the outputs keep the old pair.
  - `ovf` <= 1 and stays set until `ovf_clr`=1.
  - If `ovf_clr` and a new overflow occur in the same cycle, the set wins.
- `DEMUX12NR_OVF_EN` undefined:
  - A blocked completion overwrites `dout0`/`dout1` with the new pair, and `dvalid` stays 1 (newest data wins).
  - The `ovf` and `ovf_clr` ports are absent.

## Structure
- Shared package contains the FSM state encoding constants `ST_LO`=1'b0 and `ST_HI`=1'b1.
- One sub-module, `demux12nr_slot`: the output register pair plus `dvalid` and its handshake and overflow logic, instantiated once.
- The FSM and `hold0` live in the top level.

## Test plan
- Reset with `rst`=1 → all outputs read 0.
- Four strobes `din`=0x11,0x22,0x33,0x44 with `dready`=1 → pair (0x11,0x22) appears one cycle after the 0x22 edge, then pair (0x33,0x44); `dvalid` high for exactly one cycle each time.
- Strobe `din`=0xA1 → then 0xB2 with `sync`=1 → then 0xC3 → output pair is (0xB2,0xC3); 0xA1 is never output and `ovf`=0.
- `dready`=0 while pair (0x01,0x02) is held, then pair (0x03,0x04) completes:
  - With macro: outputs stay (0x01,0x02) and `ovf`=1; `ovf_clr` pulse → `ovf`=0.
  - Without macro: outputs become (0x03,0x04).
- `dvalid`=1, then `dready`=1 on the same edge as the completion of (0x55,0x66) → outputs become (0x55,0x66) with `dvalid` continuously 1.
- `rst` pulsed after the lane-0 sample 0x77 → next strobes 0x88,0x99 yield pair (0x88,0x99).
